conversion_counter: RTL and testbench

//  Responder side of the measurement FSM's counter interface (clear/en/limit in, done/busy out).
//  - Times the auto-zero, integrate and deintegrate phases.
//  - On the FSM's done pulse, captures the deintegrate count with ref sign and range as one result.
//  - Presents the result to the readout logic over a valid/ready handshake, with overflow and overrun flags.

---
 rtl/conversion_counter_pkg.sv | 12 +
 rtl/conversion_counter_result_holder.sv | 38 +++
 rtl/conversion_counter.sv | 82 ++++++++
 tb/tb_conversion_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conversion_counter_pkg.sv
// Shared constants for the measurement FSM and its phase counter.
package conversion_counter_pkg;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SEQ_W   = 8;
  localparam int unsigned RANGE_W = 3;

  localparam logic [CNT_W-1:0] AUTO_ZERO   = 16'h0200;
  localparam logic [CNT_W-1:0] INTEGRATE   = 16'h4000;
  localparam logic [CNT_W-1:0] DEINTEGRATE = 16'hFFFF;

endpackage

// File: rtl/conversion_counter_result_holder.sv
// Single-entry valid/ready result register with an overwrite (overrun) flag.
module conversion_counter_result_holder #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         overrun_o
);

  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_overrun;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (load_i) begin
      r_data    <= data_i;
      r_valid   <= 1'b1;
      // Overrun only when an unread result is replaced without being taken.
      r_overrun <= r_valid & ~ready_i;
    end else if (r_valid && ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign overrun_o = r_overrun;

endmodule

// File: rtl/conversion_counter.sv
// Phase counter for the measurement FSM plus capture of the deintegrate result.
module conversion_counter #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned SEQ_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cnt_clear_i,
  input  logic             cnt_en_i,
  input  logic [CNT_W-1:0] cnt_limit_i,
  output logic             cnt_done_o,
  output logic             cnt_busy_o,
  input  logic             meas_done_i,
  input  logic             ref_sign_i,
  input  logic [2:0]       range_sel_i,
  output logic [CNT_W-1:0] res_count_o,
  output logic             res_sign_o,
  output logic [2:0]       res_range_o,
  output logic             res_ovf_o,
  output logic             res_overrun_o,
  output logic [SEQ_W-1:0] res_seq_o,
  output logic             res_valid_o,
  input  logic             res_ready_i
);
  import conversion_counter_pkg::*;

  localparam int unsigned ResW = CNT_W + 1 + RANGE_W + 1 + SEQ_W;

  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic [SEQ_W-1:0] r_seq;
  logic             w_done;
  logic [ResW-1:0]  w_cap;
  logic [ResW-1:0]  w_res;

  // Stopping at the limit is what prevents wrap; limit all-ones saturates.
  assign w_done = (r_count >= cnt_limit_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (cnt_clear_i) begin
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (cnt_en_i && !w_done) begin
      r_count <= r_count + 1'b1;
      r_busy  <= 1'b1;
    end else begin
      r_busy  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_seq <= '0;
    end else if (meas_done_i) begin
      r_seq <= r_seq + 1'b1;
    end
  end

  assign w_cap = {r_count, ref_sign_i, range_sel_i, &r_count, r_seq};

  conversion_counter_result_holder #(
    .W(ResW)
  ) u_result_holder (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (meas_done_i),
    .data_i   (w_cap),
    .ready_i  (res_ready_i),
    .data_o   (w_res),
    .valid_o  (res_valid_o),
    .overrun_o(res_overrun_o)
  );

  assign {res_count_o, res_sign_o, res_range_o, res_ovf_o, res_seq_o} = w_res;

  assign cnt_done_o = w_done;
  assign cnt_busy_o = r_busy;

endmodule

// File: tb/tb_conversion_counter.sv
// Directed bench for conversion_counter: counter timing, capture, handshake, async reset.
module tb_conversion_counter;
  import conversion_counter_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cnt_clear_i, cnt_en_i;
  logic [15:0] cnt_limit_i;
  logic        cnt_done_o, cnt_busy_o;
  logic        meas_done_i, ref_sign_i;
  logic [2:0]  range_sel_i;
  logic [15:0] res_count_o;
  logic        res_sign_o;
  logic [2:0]  res_range_o;
  logic        res_ovf_o, res_overrun_o;
  logic [7:0]  res_seq_o;
  logic        res_valid_o, res_ready_i;

  int n_pass = 0;
  int n_total = 0;

  conversion_counter #(
    .CNT_W(16),
    .SEQ_W(8)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cnt_clear_i  (cnt_clear_i),
    .cnt_en_i     (cnt_en_i),
    .cnt_limit_i  (cnt_limit_i),
    .cnt_done_o   (cnt_done_o),
    .cnt_busy_o   (cnt_busy_o),
    .meas_done_i  (meas_done_i),
    .ref_sign_i   (ref_sign_i),
    .range_sel_i  (range_sel_i),
    .res_count_o  (res_count_o),
    .res_sign_o   (res_sign_o),
    .res_range_o  (res_range_o),
    .res_ovf_o    (res_ovf_o),
    .res_overrun_o(res_overrun_o),
    .res_seq_o    (res_seq_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  // Infer the hidden count from the combinational done compare, then restore the limit.
  task automatic chk_count(input string tag, input logic [15:0] exp);
    logic [15:0] saved;
    saved = cnt_limit_i;
    cnt_limit_i = exp;
    #1 chk({tag, "_ge"}, 32'(cnt_done_o), 32'd1);
    if (exp != 16'hFFFF) begin
      cnt_limit_i = exp + 16'd1;
      #1 chk({tag, "_lt"}, 32'(cnt_done_o), 32'd0);
    end
    cnt_limit_i = saved;
    #1;
  endtask

  task automatic capture(input logic sign, input logic [2:0] rng, input logic rdy);
    meas_done_i = 1'b1;
    ref_sign_i  = sign;
    range_sel_i = rng;
    res_ready_i = rdy;
    tick();
    meas_done_i = 1'b0;
    res_ready_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; cnt_clear_i = 1'b0; cnt_en_i = 1'b0; cnt_limit_i = AUTO_ZERO;
    meas_done_i = 1'b0; ref_sign_i = 1'b0; range_sel_i = 3'd0; res_ready_i = 1'b0;
    #2;
    chk("rst_valid", 32'(res_valid_o), 32'd0);
    chk("rst_busy", 32'(cnt_busy_o), 32'd0);
    chk("rst_done", 32'(cnt_done_o), 32'd0);
    chk("rst_res", {res_count_o, res_seq_o, res_sign_o, res_range_o, res_ovf_o, res_overrun_o},
        32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Auto-zero phase: done exactly 512 enabled cycles after clear.
    cnt_clear_i = 1'b1; tick(); cnt_clear_i = 1'b0;
    chk("clr_busy", 32'(cnt_busy_o), 32'd0);
    cnt_en_i = 1'b1;
    tick();
    chk("az_busy1", 32'(cnt_busy_o), 32'd1);
    tick(510);
    chk("az_done511", 32'(cnt_done_o), 32'd0);
    chk_count("az_cnt511", 16'h01FF);
    tick();
    chk("az_done512", 32'(cnt_done_o), 32'd1);
    chk("az_busy512", 32'(cnt_busy_o), 32'd1);
    tick();
    chk("az_busy_end", 32'(cnt_busy_o), 32'd0);
    chk_count("az_hold", 16'h0200);

    // Limit 0 is done at once; lowered limit gives done at once without wrap.
    cnt_clear_i = 1'b1; tick(); cnt_clear_i = 1'b0;
    cnt_limit_i = 16'h0000;
    #1 chk("lim0_done", 32'(cnt_done_o), 32'd1);
    tick();
    chk("lim0_busy", 32'(cnt_busy_o), 32'd0);
    chk_count("lim0_cnt", 16'h0000);
    cnt_clear_i = 1'b1; tick(); cnt_clear_i = 1'b0;
    cnt_limit_i = INTEGRATE;
    tick(32);
    chk_count("int_cnt", 16'h0020);
    cnt_limit_i = 16'h0010;
    #1 chk("lower_done", 32'(cnt_done_o), 32'd1);
    tick();
    chk("lower_busy", 32'(cnt_busy_o), 32'd0);
    chk_count("lower_cnt", 16'h0020);

    // Capture with ready low, then overwrite.
    cnt_clear_i = 1'b1; tick(); cnt_clear_i = 1'b0;
    cnt_limit_i = 16'h1234;
    tick(16'h1234);
    chk_count("c1_cnt", 16'h1234);
    capture(1'b1, 3'b101, 1'b0);
    chk("c1_count", 32'(res_count_o), 32'h1234);
    chk("c1_sign", 32'(res_sign_o), 32'd1);
    chk("c1_range", 32'(res_range_o), 32'd5);
    chk("c1_ovf", 32'(res_ovf_o), 32'd0);
    chk("c1_seq", 32'(res_seq_o), 32'd0);
    chk("c1_valid", 32'(res_valid_o), 32'd1);
    chk("c1_ovr", 32'(res_overrun_o), 32'd0);
    capture(1'b0, 3'b010, 1'b0);
    chk("c2_seq", 32'(res_seq_o), 32'd1);
    chk("c2_ovr", 32'(res_overrun_o), 32'd1);
    chk("c2_range", 32'(res_range_o), 32'd2);
    tick(3);
    chk("c2_stable", {16'(res_count_o), 8'(res_seq_o), 7'(res_range_o), res_valid_o},
        {16'h1234, 8'd1, 7'd2, 1'b1});

    // Capture plus transfer in the same cycle, then a plain transfer.
    capture(1'b1, 3'b011, 1'b1);
    chk("c3_valid", 32'(res_valid_o), 32'd1);
    chk("c3_ovr", 32'(res_overrun_o), 32'd0);
    chk("c3_seq", 32'(res_seq_o), 32'd2);
    chk("c3_range", 32'(res_range_o), 32'd3);
    res_ready_i = 1'b1; tick(); res_ready_i = 1'b0;
    chk("xfer_valid", 32'(res_valid_o), 32'd0);
    chk("xfer_hold", 32'(res_seq_o), 32'd2);
    for (int i = 0; i < 253; i++) capture(1'b0, 3'b000, 1'b1);
    chk("seq_255", 32'(res_seq_o), 32'd255);
    capture(1'b0, 3'b000, 1'b1);
    chk("seq_wrap", 32'(res_seq_o), 32'd0);

    // Deintegrate saturation; capture coincides with clear.
    cnt_clear_i = 1'b1; tick(); cnt_clear_i = 1'b0;
    cnt_limit_i = DEINTEGRATE;
    tick(65535);
    chk("sat_done", 32'(cnt_done_o), 32'd1);
    tick();
    chk("sat_busy", 32'(cnt_busy_o), 32'd0);
    chk_count("sat_cnt", 16'hFFFF);
    cnt_clear_i = 1'b1;
    capture(1'b0, 3'b111, 1'b1);
    cnt_clear_i = 1'b0;
    chk("sat_count", 32'(res_count_o), 32'hFFFF);
    chk("sat_ovf", 32'(res_ovf_o), 32'd1);
    chk("sat_valid", 32'(res_valid_o), 32'd1);
    chk("sat_seq", 32'(res_seq_o), 32'd1);
    chk("sat_cleared", 32'(cnt_done_o), 32'd0);

    // Asynchronous reset mid-count with a pending result.
    cnt_limit_i = INTEGRATE;
    tick(256);
    chk_count("mid_cnt", 16'h0100);
    chk("mid_valid", 32'(res_valid_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(res_valid_o), 32'd0);
    chk("arst_res", {res_count_o, res_seq_o, res_sign_o, res_range_o, res_ovf_o, res_overrun_o},
        32'd0);
    chk("arst_busy", 32'(cnt_busy_o), 32'd0);
    chk_count("arst_cnt", 16'h0000);
    @(negedge clk_i);
    rst_ni = 1'b1;
    capture(1'b1, 3'b001, 1'b0);
    chk("post_seq", 32'(res_seq_o), 32'd0);
    chk("post_count", 32'(res_count_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
